// File: rtl/codec_init_sequencer.sv
// Power-up and configuration sequencer for the pitch-shift codec: supply settling,
// codec reset pulse, table-driven register writes with retry, then audio enable.
module codec_init_sequencer #(
  parameter int unsigned NUM_WRITES    = 11,
  parameter int unsigned POWERUP_DELAY = 1023,
  parameter int unsigned RST_WIDTH     = 15,
  parameter int unsigned SETTLE_DELAY  = 255,
  parameter int unsigned GAP_DELAY     = 31,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned IW            = (NUM_WRITES > 1) ? $clog2(NUM_WRITES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic [IW-1:0] cfg_index,
  input  logic [15:0]   cfg_word,
  output logic          wr_req,
  output logic [15:0]   wr_word,
  input  logic          wr_ack,
  input  logic          wr_err,
  output logic          codec_rst_n,
  output logic          audio_en,
  output logic          done,
  output logic          error
);

  localparam int unsigned MAX_A = (POWERUP_DELAY > RST_WIDTH) ? POWERUP_DELAY : RST_WIDTH;
  localparam int unsigned MAX_B = (SETTLE_DELAY > GAP_DELAY) ? SETTLE_DELAY : GAP_DELAY;
  localparam int unsigned MAXD  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned TW    = $clog2(MAXD + 1);
  localparam int unsigned RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [2:0] S_PWRUP    = 3'd0;
  localparam logic [2:0] S_RSTPULSE = 3'd1;
  localparam logic [2:0] S_SETTLE   = 3'd2;
  localparam logic [2:0] S_FETCH    = 3'd3;
  localparam logic [2:0] S_REQ      = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;
  localparam logic [2:0] S_ERR      = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          armed_q, armed_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          req_q, req_d;
  logic [15:0]   word_q, word_d;
  logic          rstn_q, rstn_d;
  logic          aen_q, aen_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    armed_d = armed_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    req_d   = req_q;
    word_d  = word_q;
    rstn_d  = rstn_q;
    aen_d   = aen_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      // Reset leaves the timer at zero, so PWRUP spends its first cycle loading it.
      S_PWRUP: begin
        if (!armed_q) begin
          armed_d = 1'b1;
          timer_d = TW'(POWERUP_DELAY - 1);
        end else if (timer_q == '0) begin
          state_d = S_RSTPULSE;
          timer_d = TW'(RST_WIDTH - 1);
          rstn_d  = 1'b0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_RSTPULSE: begin
        if (timer_q == '0) begin
          state_d = S_SETTLE;
          timer_d = TW'(SETTLE_DELAY - 1);
          rstn_d  = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_SETTLE: begin
        if (timer_q == '0) state_d = S_FETCH;
        else               timer_d = timer_q - TW'(1);
      end
      S_FETCH: begin
        word_d  = cfg_word;
        req_d   = 1'b1;
        state_d = S_REQ;
      end
      // An error response takes priority over a simultaneous ack.
      S_REQ: begin
        if (wr_err) begin
          req_d = 1'b0;
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = S_GAP;
            timer_d = TW'(GAP_DELAY - 1);
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
            rstn_d  = 1'b0;
            aen_d   = 1'b0;
          end
        end else if (wr_ack) begin
          req_d = 1'b0;
          if (idx_q == IW'(NUM_WRITES - 1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            aen_d   = 1'b1;
          end else begin
            idx_d   = idx_q + IW'(1);
            retry_d = '0;
            state_d = S_GAP;
            timer_d = TW'(GAP_DELAY - 1);
          end
        end
      end
      S_GAP: begin
        if (timer_q == '0) state_d = S_FETCH;
        else               timer_d = timer_q - TW'(1);
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_PWRUP;
      timer_q <= '0;
      armed_q <= 1'b0;
      idx_q   <= '0;
      retry_q <= '0;
      req_q   <= 1'b0;
      word_q  <= '0;
      rstn_q  <= 1'b1;
      aen_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      armed_q <= armed_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      req_q   <= req_d;
      word_q  <= word_d;
      rstn_q  <= rstn_d;
      aen_q   <= aen_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cfg_index   = idx_q;
  assign wr_req      = req_q;
  assign wr_word     = word_q;
  assign codec_rst_n = rstn_q;
  assign audio_en    = aen_q;
  assign done        = done_q;
  assign error       = err_q;

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Directed bench for codec_init_sequencer: default instance with a latency-2 engine
// model, plus a minimal instance (one write, unit delays) with a zero-wait engine.
module tb_codec_init_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  cfg_index;
  logic [15:0] cfg_word;
  logic        wr_req;
  logic [15:0] wr_word;
  logic        wr_ack, wr_err;
  logic        codec_rst_n, audio_en, done, error;

  logic        s_reset;
  logic [0:0]  s_cfg_index;
  logic [15:0] s_cfg_word;
  logic        s_wr_req;
  logic [15:0] s_wr_word;
  logic        s_wr_ack, s_wr_err;
  logic        s_codec_rst_n, s_audio_en, s_done, s_error;

  codec_init_sequencer u_dut (
    .clk(clk), .reset(reset), .cfg_index(cfg_index), .cfg_word(cfg_word),
    .wr_req(wr_req), .wr_word(wr_word), .wr_ack(wr_ack), .wr_err(wr_err),
    .codec_rst_n(codec_rst_n), .audio_en(audio_en), .done(done), .error(error)
  );

  codec_init_sequencer #(
    .NUM_WRITES(1), .POWERUP_DELAY(1), .RST_WIDTH(1), .SETTLE_DELAY(1), .GAP_DELAY(1)
  ) u_small (
    .clk(clk), .reset(s_reset), .cfg_index(s_cfg_index), .cfg_word(s_cfg_word),
    .wr_req(s_wr_req), .wr_word(s_wr_word), .wr_ack(s_wr_ack), .wr_err(s_wr_err),
    .codec_rst_n(s_codec_rst_n), .audio_en(s_audio_en), .done(s_done), .error(s_error)
  );

  function automatic logic [15:0] rom_val(input int unsigned i);
    return 16'hC0DE ^ 16'(i * 32'h123 + 7);
  endfunction

  // Configuration ROM model: one-cycle read latency.
  always @(posedge clk) cfg_word   <= rom_val(32'(cfg_index));
  always @(posedge clk) s_cfg_word <= rom_val(32'(s_cfg_index));

  int checks = 0;
  int failures = 0;

  // Engine model: responds in the third cycle of each request, per-entry plans.
  int nerr[16];
  int nboth[16];
  bit hold;
  int lat;
  initial begin
    wr_ack = 1'b0; wr_err = 1'b0; lat = 0;
    forever begin
      @(posedge clk); #1;
      wr_ack = 1'b0; wr_err = 1'b0;
      if (wr_req === 1'b1 && !hold && !reset) begin
        if (lat == 2) begin
          lat = 0;
          if (nboth[cfg_index] > 0) begin
            nboth[cfg_index]--; wr_ack = 1'b1; wr_err = 1'b1;
          end else if (nerr[cfg_index] > 0) begin
            nerr[cfg_index]--; wr_err = 1'b1;
          end else begin
            wr_ack = 1'b1;
          end
        end else begin
          lat++;
        end
      end else begin
        lat = 0;
      end
    end
  end

  // Monitor: cycle numbering starts at 0 on the first edge with reset low.
  int cyc, req_n, rst_lo_start, rst_lo_cnt, done_cyc, err_cyc, viol, req_after_err;
  logic [15:0] req_word[16];
  int req_idx[16];
  int req_cyc[16];
  logic prev_req;
  logic [15:0] prev_word;
  initial begin
    prev_req = 1'b0; prev_word = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        cyc = -1; req_n = 0; rst_lo_start = -1; rst_lo_cnt = 0;
        done_cyc = -1; err_cyc = -1; viol = 0; req_after_err = 0;
      end else begin
        cyc++;
        if (wr_req && !prev_req) begin
          if (req_n < 16) begin
            req_word[req_n] = wr_word; req_idx[req_n] = 32'(cfg_index); req_cyc[req_n] = cyc;
          end
          req_n++;
          if (error) req_after_err++;
        end
        if (wr_req && prev_req && wr_word !== prev_word) viol++;
        if (!codec_rst_n && !error) begin
          if (rst_lo_cnt == 0) rst_lo_start = cyc;
          rst_lo_cnt++;
        end
        if (done && done_cyc < 0) done_cyc = cyc;
        if (error && err_cyc < 0) err_cyc = cyc;
      end
      prev_req = wr_req; prev_word = wr_word;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    hold = 1'b0;
    for (int i = 0; i < 16; i++) begin nerr[i] = 0; nboth[i] = 0; end
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_term(input int budget, output bit timed_out);
    int n;
    n = 0;
    while (!(done === 1'b1 || error === 1'b1) && n < budget) begin
      @(negedge clk); n++;
    end
    timed_out = !(done === 1'b1 || error === 1'b1);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (wr_req !== 1'b0) begin failures++; $display("FAIL reset_wr_req got=%0h exp=0", wr_req); end
    checks++; if (wr_word !== 16'h0) begin failures++; $display("FAIL reset_wr_word got=%0h exp=0", wr_word); end
    checks++; if (cfg_index !== 4'd0) begin failures++; $display("FAIL reset_cfg_index got=%0d exp=0", cfg_index); end
    checks++; if (codec_rst_n !== 1'b1) begin failures++; $display("FAIL reset_codec_rst_n got=%0h exp=1", codec_rst_n); end
    checks++; if ({audio_en, done, error} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {audio_en, done, error});
    end
  endtask

  task automatic test_defaults();
    bit to;
    do_reset();
    wait_term(3000, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL def_timeout got=%0d exp=0", to); end
    checks++; if (rst_lo_start !== 1023) begin failures++; $display("FAIL def_rst_start got=%0d exp=1023", rst_lo_start); end
    checks++; if (rst_lo_cnt !== 15) begin failures++; $display("FAIL def_rst_width got=%0d exp=15", rst_lo_cnt); end
    checks++; if (req_n !== 11) begin failures++; $display("FAIL def_req_count got=%0d exp=11", req_n); end
    checks++; if (req_cyc[0] !== 1294) begin failures++; $display("FAIL def_first_req got=%0d exp=1294", req_cyc[0]); end
    checks++; if (req_cyc[1] - req_cyc[0] !== 35) begin
      failures++; $display("FAIL def_req_period got=%0d exp=35", req_cyc[1] - req_cyc[0]);
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (req_word[i] !== rom_val(i) || req_idx[i] !== i) begin
        failures++; $display("FAIL def_word[%0d] got=%0h/%0d exp=%0h/%0d", i, req_word[i], req_idx[i], rom_val(i), i);
      end
    end
    checks++; if (done_cyc !== 1647) begin failures++; $display("FAIL def_done_cycle got=%0d exp=1647", done_cyc); end
    @(negedge clk);
    checks++; if ({done, audio_en, error, codec_rst_n} !== 4'b1101) begin
      failures++; $display("FAIL def_final got=%b exp=1101", {done, audio_en, error, codec_rst_n});
    end
    checks++; if (cfg_index !== 4'd10) begin failures++; $display("FAIL def_last_index got=%0d exp=10", cfg_index); end
    checks++; if (err_cyc !== -1 || viol !== 0) begin
      failures++; $display("FAIL def_err_or_unstable got=%0d/%0d exp=-1/0", err_cyc, viol);
    end
  endtask

  task automatic test_nack_once();
    bit to;
    do_reset();
    nerr[4] = 1;
    wait_term(3000, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL nack1_timeout got=%0d exp=0", to); end
    checks++; if (req_n !== 12) begin failures++; $display("FAIL nack1_req_count got=%0d exp=12", req_n); end
    checks++; if (req_idx[5] !== 4 || req_word[5] !== rom_val(4) || req_word[4] !== rom_val(4)) begin
      failures++; $display("FAIL nack1_reissue got=%0d/%0h/%0h exp=4/%0h", req_idx[5], req_word[4], req_word[5], rom_val(4));
    end
    checks++; if (req_cyc[5] - req_cyc[4] !== 35) begin
      failures++; $display("FAIL nack1_gap got=%0d exp=35", req_cyc[5] - req_cyc[4]);
    end
    checks++; if (req_idx[6] !== 5) begin failures++; $display("FAIL nack1_next got=%0d exp=5", req_idx[6]); end
    checks++; if (done_cyc !== 1682 || error !== 1'b0) begin
      failures++; $display("FAIL nack1_done got=%0d/%0h exp=1682/0", done_cyc, error);
    end
  endtask

  task automatic test_nack_exhaust();
    bit to;
    do_reset();
    nerr[2] = 4;
    wait_term(3000, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL nack4_timeout got=%0d exp=0", to); end
    checks++; if (err_cyc !== 1472) begin failures++; $display("FAIL nack4_err_cycle got=%0d exp=1472", err_cyc); end
    repeat (200) @(negedge clk);
    checks++; if (req_n !== 6 || req_after_err !== 0) begin
      failures++; $display("FAIL nack4_req_count got=%0d/%0d exp=6/0", req_n, req_after_err);
    end
    checks++; if ({error, codec_rst_n, done, audio_en, wr_req} !== 5'b10000) begin
      failures++; $display("FAIL nack4_final got=%b exp=10000", {error, codec_rst_n, done, audio_en, wr_req});
    end
  endtask

  task automatic test_ack_err_same();
    bit to;
    do_reset();
    nboth[0] = 1;
    nerr[0] = 3;
    wait_term(3000, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL both_timeout got=%0d exp=0", to); end
    checks++; if (req_n !== 4 || req_idx[1] !== 0 || req_idx[3] !== 0) begin
      failures++; $display("FAIL both_reqs got=%0d/%0d/%0d exp=4/0/0", req_n, req_idx[1], req_idx[3]);
    end
    checks++; if (err_cyc !== 1402 || done !== 1'b0) begin
      failures++; $display("FAIL both_err got=%0d/%0h exp=1402/0", err_cyc, done);
    end
  endtask

  task automatic test_stall();
    bit to;
    int n, changes;
    logic [15:0] w0;
    logic [3:0]  i0;
    logic [4:0]  f0;
    do_reset();
    hold = 1'b1;
    n = 0;
    while (wr_req !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    checks++; if (wr_req !== 1'b1) begin failures++; $display("FAIL stall_req_seen got=%0h exp=1", wr_req); end
    w0 = wr_word; i0 = cfg_index; f0 = {wr_req, codec_rst_n, audio_en, done, error};
    changes = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (wr_word !== w0 || cfg_index !== i0 || {wr_req, codec_rst_n, audio_en, done, error} !== f0) changes++;
    end
    checks++; if (changes !== 0) begin failures++; $display("FAIL stall_hold got=%0d exp=0", changes); end
    checks++; if (w0 !== rom_val(0) || f0 !== 5'b11000) begin
      failures++; $display("FAIL stall_values got=%0h/%b exp=%0h/11000", w0, f0, rom_val(0));
    end
    hold = 1'b0;
    wait_term(3000, to);
    checks++; if (to !== 1'b0 || done !== 1'b1) begin
      failures++; $display("FAIL stall_resume got=%0d/%0h exp=0/1", to, done);
    end
  endtask

  task automatic test_reset_mid_req();
    bit to;
    int n;
    do_reset();
    n = 0;
    while (!(wr_req === 1'b1 && cfg_index === 4'd6) && n < 3000) begin @(negedge clk); n++; end
    checks++; if (cfg_index !== 4'd6 || wr_req !== 1'b1) begin
      failures++; $display("FAIL mid_reach got=%0d/%0h exp=6/1", cfg_index, wr_req);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (wr_req !== 1'b0 || cfg_index !== 4'd0) begin
      failures++; $display("FAIL mid_reset got=%0h/%0d exp=0/0", wr_req, cfg_index);
    end
    @(negedge clk);
    reset = 1'b0;
    wait_term(3000, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL mid_timeout got=%0d exp=0", to); end
    checks++; if (rst_lo_start !== 1023 || rst_lo_cnt !== 15) begin
      failures++; $display("FAIL mid_rst got=%0d/%0d exp=1023/15", rst_lo_start, rst_lo_cnt);
    end
    checks++; if (req_cyc[0] !== 1294 || req_n !== 11 || done_cyc !== 1647) begin
      failures++; $display("FAIL mid_restart got=%0d/%0d/%0d exp=1294/11/1647", req_cyc[0], req_n, done_cyc);
    end
  endtask

  task automatic test_single();
    int req_k, lo_k, lo_n, done_k;
    logic [15:0] w;
    req_k = -1; lo_k = -1; lo_n = 0; done_k = -1; w = '0;
    s_wr_ack = 1'b0;
    @(negedge clk);
    s_reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (s_wr_req === 1'b1 && req_k < 0) begin req_k = k; w = s_wr_word; end
      if (s_codec_rst_n === 1'b0) begin if (lo_k < 0) lo_k = k; lo_n++; end
      if (s_done === 1'b1 && done_k < 0) done_k = k;
      s_wr_ack = s_wr_req;
    end
    s_wr_ack = 1'b0;
    checks++; if (lo_k !== 1 || lo_n !== 1) begin failures++; $display("FAIL single_rst got=%0d/%0d exp=1/1", lo_k, lo_n); end
    checks++; if (req_k !== 4 || w !== rom_val(0)) begin
      failures++; $display("FAIL single_req got=%0d/%0h exp=4/%0h", req_k, w, rom_val(0));
    end
    checks++; if (done_k !== 5) begin failures++; $display("FAIL single_done_cycle got=%0d exp=5", done_k); end
    checks++; if ({s_done, s_audio_en, s_error, s_wr_req} !== 4'b1100) begin
      failures++; $display("FAIL single_final got=%b exp=1100", {s_done, s_audio_en, s_error, s_wr_req});
    end
  endtask

  initial begin
    reset = 1'b1;
    s_reset = 1'b1;
    s_wr_ack = 1'b0;
    s_wr_err = 1'b0;
    hold = 1'b0;
    for (int i = 0; i < 16; i++) begin nerr[i] = 0; nboth[i] = 0; end
    test_reset();
    test_defaults();
    test_nack_once();
    test_nack_exhaust();
    test_ack_err_same();
    test_stall();
    test_reset_mid_req();
    test_single();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
